// File: rtl/axi_llc_pkg.sv
// rtl/axi_llc_pkg.sv - shared LLC types: configuration, cache units, scheduler states
package axi_llc_pkg;

  typedef struct packed {
    logic [31:0] SetAssociativity;
    logic [31:0] NumLines;
    logic [31:0] NumBlocks;
    logic [31:0] BlockSize;
  } llc_cfg_t;

  typedef enum logic [1:0] {
    EvictUnit  = 2'd0,
    RefilUnit  = 2'd1,
    MissUnit   = 2'd2,
    HitUnit    = 2'd3
  } cache_unit_e;

  typedef logic [1:0] sched_state_e;
  localparam sched_state_e RUN   = 2'd0;
  localparam sched_state_e DRAIN = 2'd1;
  localparam sched_state_e HOLD  = 2'd2;

  // Default miss descriptor; any replacement must keep single-bit evict/refill fields.
  typedef struct packed {
    logic [63:0] a_x_addr;
    logic [7:0]  a_x_len;
    logic [3:0]  a_x_id;
    logic        evict;
    logic        refill;
  } llc_desc_t;

endpackage

// File: rtl/axi_llc_credit_cnt.sv
// rtl/axi_llc_credit_cnt.sv - outstanding-burst credit counter, saturating at zero on stray returns
module axi_llc_credit_cnt
  import axi_llc_pkg::*;
#(
  parameter int unsigned Max = 4,
  parameter int unsigned W   = $clog2(Max + 1)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         take_i,
  input  logic         give_i,
  output logic [W-1:0] cnt_o,
  output logic         avail_o
);

  localparam logic [W-1:0] MaxCnt = W'(Max);
  localparam logic [W-1:0] One    = W'(1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (take_i && !give_i) begin
      cnt_d = cnt_q + One;
    end else if (give_i && !take_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - One;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o   = cnt_q;
  assign avail_o = (cnt_q < MaxCnt);

`ifndef SYNTHESIS
  a_no_underflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(give_i && !take_i && (cnt_q == '0)))
    else $error("credit returned while no burst outstanding");
`endif

endmodule

// File: rtl/axi_llc_miss_scheduler.sv
// rtl/axi_llc_miss_scheduler.sv - credit-gated admission of miss descriptors with drain handshake
module axi_llc_miss_scheduler
  import axi_llc_pkg::*;
#(
  parameter llc_cfg_t    Cfg        = llc_cfg_t'('1),
  parameter type         desc_t     = llc_desc_t,
  parameter int unsigned MaxEvict   = 4,
  parameter int unsigned MaxRefill  = 4,
  parameter int unsigned EvictCntW  = $clog2(MaxEvict + 1),
  parameter int unsigned RefillCntW = $clog2(MaxRefill + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  desc_t                 desc_i,
  input  logic                  desc_valid_i,
  output logic                  desc_ready_o,
  output desc_t                 desc_o,
  output logic                  desc_valid_o,
  input  logic                  desc_ready_i,
  input  logic                  evict_done_i,
  input  logic                  refill_done_i,
  input  logic                  drain_req_i,
  output logic                  drain_ack_o,
  output logic [EvictCntW-1:0]  evict_cnt_o,
  output logic [RefillCntW-1:0] refill_cnt_o
);

  sched_state_e state_q, state_d;
  logic         desc_valid_q, desc_valid_d;
  desc_t        desc_q, desc_d;
  logic         evict_avail, refill_avail;
  logic         credit_ok, out_free, accept;

  // Credit check only looks at desc_i when it is valid, so ready never depends on junk.
  assign credit_ok = !desc_valid_i ||
                     ((!desc_i.evict || evict_avail) && (!desc_i.refill || refill_avail));
  assign out_free  = !desc_valid_q || desc_ready_i;
  // A drain request wins over admission in the same cycle.
  assign desc_ready_o = (state_q == RUN) && !drain_req_i && credit_ok && out_free;
  assign accept       = desc_valid_i && desc_ready_o;

  axi_llc_credit_cnt #(.Max(MaxEvict), .W(EvictCntW)) i_evict_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .take_i  (accept && desc_i.evict),
    .give_i  (evict_done_i),
    .cnt_o   (evict_cnt_o),
    .avail_o (evict_avail)
  );

  axi_llc_credit_cnt #(.Max(MaxRefill), .W(RefillCntW)) i_refill_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .take_i  (accept && desc_i.refill),
    .give_i  (refill_done_i),
    .cnt_o   (refill_cnt_o),
    .avail_o (refill_avail)
  );

  always_comb begin
    desc_d       = desc_q;
    desc_valid_d = desc_valid_q;
    if (accept) begin
      desc_d       = desc_i;
      desc_valid_d = 1'b1;
    end else if (desc_ready_i) begin
      desc_valid_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:   if (drain_req_i) state_d = DRAIN;
      DRAIN: if (!desc_valid_q && (evict_cnt_o == '0) && (refill_cnt_o == '0)) state_d = HOLD;
      HOLD:  if (!drain_req_i) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= RUN;
      desc_valid_q <= 1'b0;
      desc_q       <= '0;
    end else begin
      state_q      <= state_d;
      desc_valid_q <= desc_valid_d;
      desc_q       <= desc_d;
    end
  end

  assign desc_o       = desc_q;
  assign desc_valid_o = desc_valid_q;
  assign drain_ack_o  = (state_q == HOLD);

`ifndef SYNTHESIS
  a_cfg_sane : assert property (@(posedge clk_i) disable iff (!rst_ni)
    Cfg.SetAssociativity != '0)
    else $error("LLC configuration has zero associativity");
`endif

endmodule

// File: tb/tb_axi_llc_miss_scheduler.sv
// tb/tb_axi_llc_miss_scheduler.sv - bench for the LLC miss scheduler
module tb_axi_llc_miss_scheduler;

  typedef struct packed {
    logic [7:0] tag;
    logic       evict;
    logic       refill;
  } tb_desc_t;

  typedef struct {
    bit v; bit e; bit r; bit rdy; bit evd; bit rfd;
    int tag;
    bit exp_rdy; int exp_ev; int exp_rf; bit exp_vo; int exp_tag;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  tb_desc_t   din = '0;
  logic       din_valid = 1'b0;
  logic       din_ready;
  tb_desc_t   dout;
  logic       dout_valid;
  logic       dout_ready = 1'b0;
  logic       evd = 1'b0;
  logic       rfd = 1'b0;
  logic       drain_req = 1'b0;
  logic       drain_ack;
  logic [1:0] ev_cnt;
  logic [2:0] rf_cnt;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  axi_llc_miss_scheduler #(
    .desc_t    (tb_desc_t),
    .MaxEvict  (2),
    .MaxRefill (4)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .desc_i        (din),
    .desc_valid_i  (din_valid),
    .desc_ready_o  (din_ready),
    .desc_o        (dout),
    .desc_valid_o  (dout_valid),
    .desc_ready_i  (dout_ready),
    .evict_done_i  (evd),
    .refill_done_i (rfd),
    .drain_req_i   (drain_req),
    .drain_ack_o   (drain_ack),
    .evict_cnt_o   (ev_cnt),
    .refill_cnt_o  (rf_cnt)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int pk(input int tag, input bit e, input bit r);
    return (tag & 255) * 4 + int'(e) * 2 + int'(r);
  endfunction

  task automatic drive(input bit v, input bit e, input bit r, input int tag,
                       input bit rdy, input bit ed, input bit rd);
    din_valid  = v;
    din.evict  = e;
    din.refill = r;
    din.tag    = tag[7:0];
    dout_ready = rdy;
    evd        = ed;
    rfd        = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[10];

  int  m_ev, m_rf, m_st, m_tag;
  bit  m_vq;

  initial begin
    // credit saturation, independent credits, simultaneous take/return (MaxEvict=2)
    tbl[0] = '{1,1,0,1,0,0, 16, 1, 1,0, 1,pk(16,1,0)};
    tbl[1] = '{1,1,0,1,0,0, 17, 1, 2,0, 1,pk(17,1,0)};
    tbl[2] = '{1,1,0,1,0,0, 18, 0, 2,0, 0,0};
    tbl[3] = '{1,1,0,1,1,0, 18, 0, 1,0, 0,0};
    tbl[4] = '{1,1,0,1,0,0, 18, 1, 2,0, 1,pk(18,1,0)};
    tbl[5] = '{1,0,1,1,0,0, 21, 1, 2,1, 1,pk(21,0,1)};
    tbl[6] = '{1,0,0,1,1,0, 22, 1, 1,1, 1,pk(22,0,0)};
    tbl[7] = '{1,1,0,1,1,0, 23, 1, 1,1, 1,pk(23,1,0)};
    tbl[8] = '{0,0,0,1,0,1, 24, 1, 1,0, 0,0};
    tbl[9] = '{0,0,0,1,1,0, 25, 1, 0,0, 0,0};

    #4;
    chk("reset valid", dout_valid, 0);
    chk("reset ack", drain_ack, 0);
    chk("reset evcnt", ev_cnt, 0);
    chk("reset rfcnt", rf_cnt, 0);
    chk("reset desc", int'(dout), 0);
    #8 rst_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].v, tbl[i].e, tbl[i].r, tbl[i].tag, tbl[i].rdy, tbl[i].evd, tbl[i].rfd);
      #1;
      chk($sformatf("tbl%0d ready", i), din_ready, tbl[i].exp_rdy);
      tick();
      chk($sformatf("tbl%0d evcnt", i), ev_cnt, tbl[i].exp_ev);
      chk($sformatf("tbl%0d rfcnt", i), rf_cnt, tbl[i].exp_rf);
      chk($sformatf("tbl%0d valid", i), dout_valid, tbl[i].exp_vo);
      if (tbl[i].exp_vo) chk($sformatf("tbl%0d desc", i), int'(dout), tbl[i].exp_tag);
    end

    // backpressure
    drive(1, 1, 0, 'hA5, 0, 0, 0);
    #1 chk("bp first ready", din_ready, 1);
    tick();
    drive(1, 0, 1, 'h5A, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      #1 chk("bp ready low", din_ready, 0);
      tick();
      chk("bp desc hold", int'(dout), pk('hA5, 1, 0));
      chk("bp valid hold", dout_valid, 1);
      chk("bp evcnt", ev_cnt, 1);
      chk("bp rfcnt", rf_cnt, 0);
    end
    dout_ready = 1'b1;
    #1 chk("bp release ready", din_ready, 1);
    tick();
    chk("bp next desc", int'(dout), pk('h5A, 0, 1));
    chk("bp rfcnt after", rf_cnt, 1);
    drive(0, 0, 0, 0, 1, 1, 1);
    tick();
    chk("bp empty", dout_valid, 0);
    chk("bp ev zero", ev_cnt, 0);
    chk("bp rf zero", rf_cnt, 0);

    // drain with 1 evict + 2 refills outstanding
    drive(1, 1, 1, 'h11, 1, 0, 0);
    tick();
    drive(1, 0, 1, 'h12, 1, 0, 0);
    tick();
    drive(0, 0, 0, 0, 1, 0, 0);
    tick();
    chk("dr setup ev", ev_cnt, 1);
    chk("dr setup rf", rf_cnt, 2);
    chk("dr setup empty", dout_valid, 0);
    drive(1, 0, 0, 'h33, 1, 0, 0);
    drain_req = 1'b1;
    #1 chk("dr ready blocked", din_ready, 0);
    tick();
    chk("dr no accept", dout_valid, 0);
    chk("dr ack early", drain_ack, 0);
    evd = 1'b1;
    tick();
    chk("dr ev0", ev_cnt, 0);
    chk("dr ack pend1", drain_ack, 0);
    evd = 1'b0; rfd = 1'b1;
    tick();
    chk("dr rf1", rf_cnt, 1);
    tick();
    chk("dr rf0", rf_cnt, 0);
    chk("dr ack pend2", drain_ack, 0);
    rfd = 1'b0;
    tick();
    chk("dr ack up", drain_ack, 1);
    chk("dr hold ready", din_ready, 0);
    drain_req = 1'b0;
    #1 chk("dr ack still", drain_ack, 1);
    tick();
    chk("dr ack clear", drain_ack, 0);
    chk("dr still empty", dout_valid, 0);
    chk("dr run ready", din_ready, 1);
    tick();
    chk("dr accepted", dout_valid, 1);
    chk("dr accepted desc", int'(dout), pk('h33, 0, 0));

    // asynchronous reset mid-stream
    drive(1, 1, 1, 'h40, 1, 0, 0);
    tick();
    drive(1, 0, 1, 'h41, 1, 0, 0);
    tick();
    drive(1, 0, 1, 'h42, 1, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("rs pre ev", ev_cnt, 1);
    chk("rs pre rf", rf_cnt, 3);
    chk("rs pre valid", dout_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rs ev", ev_cnt, 0);
    chk("rs rf", rf_cnt, 0);
    chk("rs valid", dout_valid, 0);
    chk("rs ack", drain_ack, 0);
    chk("rs desc", int'(dout), 0);
    #1 rst_n = 1'b1;
    drive(1, 1, 0, 'h50, 1, 0, 0);
    #1 chk("rs accept ready", din_ready, 1);
    tick();
    chk("rs accept valid", dout_valid, 1);
    chk("rs accept ev", ev_cnt, 1);
    chk("rs accept desc", int'(dout), pk('h50, 1, 0));

    // randomized run against a transaction-level model
    drive(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    m_ev = 0; m_rf = 0; m_st = 0; m_vq = 0; m_tag = 0;
    for (int c = 0; c < 400; c++) begin
      bit v, e, r, rdy, ed, rd, exp_rdy, acc, vq_old;
      int tag, n_st;
      v   = ($urandom_range(0, 3) != 0);
      e   = 1'($urandom_range(0, 1));
      r   = 1'($urandom_range(0, 1));
      rdy = ($urandom_range(0, 3) != 0);
      tag = int'($urandom_range(0, 255));
      ed  = (m_ev > 0) && ($urandom_range(0, 2) == 0);
      rd  = (m_rf > 0) && ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 24) == 0) drain_req = !drain_req;
      drive(v, e, r, tag, rdy, ed, rd);
      #1;
      exp_rdy = (m_st == 0) && !drain_req && (!m_vq || rdy) &&
                (!v || ((!e || m_ev < 2) && (!r || m_rf < 4)));
      chk("rnd ready", din_ready, exp_rdy);
      tick();
      acc    = v && exp_rdy;
      vq_old = m_vq;
      n_st   = m_st;
      if (m_st == 0 && drain_req) n_st = 1;
      else if (m_st == 1 && !vq_old && m_ev == 0 && m_rf == 0) n_st = 2;
      else if (m_st == 2 && !drain_req) n_st = 0;
      m_ev = m_ev + ((acc && e) ? 1 : 0) - (ed ? 1 : 0);
      m_rf = m_rf + ((acc && r) ? 1 : 0) - (rd ? 1 : 0);
      if (acc) begin
        m_vq = 1; m_tag = pk(tag, e, r);
      end else if (rdy) begin
        m_vq = 0;
      end
      m_st = n_st;
      chk("rnd evcnt", ev_cnt, m_ev);
      chk("rnd rfcnt", rf_cnt, m_rf);
      chk("rnd valid", dout_valid, m_vq);
      chk("rnd ack", drain_ack, (m_st == 2) ? 1 : 0);
      if (m_vq) chk("rnd desc", int'(dout), m_tag);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
